// File: rtl/mem_access_if.sv
// Request/response handshake bundle between the execute stage, the load/store unit
// and the write-back stage.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for the big-endian byte-addressed data memory.
// Define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned half/word accesses.
//
// state   | meaning
// IDLE    | ready for a request; errors go straight to RESP
// ACCESS  | memory enabled for one cycle with the latched request
// CAPTURE | load word arrives; extract and extend it
// RESP    | response held until write-back accepts it
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 8096
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus,
  output logic         mem_en_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_wr_o,
  output logic [1:0]   mem_wscope_o,
  output logic [31:0]  mem_wdata_o,
  input  logic [31:0]  mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  logic [2:0]  req_nbytes;
  logic [32:0] req_end;
  logic        req_misalign;
  logic        req_err;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    req_nbytes = 3'd1;
    if (bus.req_size == 2'b11) begin
      req_nbytes = 3'd4;
    end else if (bus.req_size == 2'b01) begin
      req_nbytes = 3'd2;
    end
    req_end      = {1'b0, bus.req_addr} + {30'd0, req_nbytes};
    req_misalign = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    req_misalign = ((bus.req_size == 2'b11) && (bus.req_addr[1:0] != 2'b00)) ||
                   ((bus.req_size == 2'b01) && bus.req_addr[0]);
`else
    req_misalign = 1'b0;
`endif
    req_err = (bus.req_size == 2'b10) || (req_end > 33'(MEM_BYTES)) || req_misalign;
  end

  // Lane selection uses only the address bits the memory honours for the size.
  always_comb begin
    half_sel = addr_q[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata_i[31:24];
      2'd1:    byte_sel = mem_rdata_i[23:16];
      2'd2:    byte_sel = mem_rdata_i[15:8];
      default: byte_sel = mem_rdata_i[7:0];
    endcase
    case (size_q)
      2'b11:   load_val = mem_rdata_i;
      2'b01:   load_val = sgn_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_val = sgn_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_wr;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rd_d    = bus.req_rd;
          data_d  = '0;
          err_d   = req_err;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        state_d = wr_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        data_d  = load_val;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_err   = err_q;

  assign mem_en_o     = (state_q == ACCESS);
  assign mem_addr_o   = addr_q;
  assign mem_wr_o     = wr_q;
  assign mem_wscope_o = size_q;
  assign mem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, a big-endian memory stub and
// directed vectors with hand-computed results.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [1:0]  mem_wscope;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_access_if bus();

  mem_access_unit #(.MEM_BYTES(8096)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_wr_o(mem_wr),
    .mem_wscope_o(mem_wscope), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  dev[8192] = '{default: 8'h00};
  logic [7:0]  ref_mem[8192] = '{default: 8'h00};
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_data;
  logic        last_err;
  int          last_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Memory stub: one-cycle read latency, big-endian lanes, forced alignment.
  initial begin
    logic [12:0] wa, ha;
    forever begin
      @(posedge clk);
      cyc++;
      wa = {mem_addr[12:2], 2'b00};
      ha = {mem_addr[12:1], 1'b0};
      mem_rdata <= '0;
      if (mem_en) begin
        if (mem_wr) begin
          case (mem_wscope)
            2'b11: begin
              dev[wa] = mem_wdata[31:24]; dev[wa + 13'd1] = mem_wdata[23:16];
              dev[wa + 13'd2] = mem_wdata[15:8]; dev[wa + 13'd3] = mem_wdata[7:0];
            end
            2'b01: begin
              dev[ha] = mem_wdata[15:8]; dev[ha + 13'd1] = mem_wdata[7:0];
            end
            default: dev[mem_addr[12:0]] = mem_wdata[7:0];
          endcase
        end else begin
          mem_rdata <= {dev[wa], dev[wa + 13'd1], dev[wa + 13'd2], dev[wa + 13'd3]};
        end
      end
    end
  end

  // Reference: size in bytes, bounds, alignment, then big-endian byte gathering.
  function automatic exp_t model(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd);
    exp_t e;
    int nb, base;
    logic [31:0] v;
    e.wr = wr; e.size = size; e.addr = addr; e.wdata = wdata; e.rd = rd;
    e.acc = 0; e.data = '0;
    nb = (size == 2'b11) ? 4 : (size == 2'b01) ? 2 : 1;
    e.err = (size == 2'b10) || (longint'(addr) + longint'(nb) > 64'd8096);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((longint'(addr) % nb) != 0) e.err = 1'b1;
`endif
    if (e.err) begin
      e.lat = 1;
    end else begin
      base = int'(addr) / nb * nb;
      if (wr) begin
        e.lat = 2;
        for (int k = 0; k < nb; k++) ref_mem[base + k] = wdata[8 * (nb - 1 - k) +: 8];
      end else begin
        e.lat = 3;
        v = '0;
        for (int k = 0; k < nb; k++) v = (v << 8) | {24'd0, ref_mem[base + k]};
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        e.data = v;
      end
    end
    return e;
  endfunction

  // Per-cycle compare against the head of the expectation queue.
  initial begin
    logic        seen;
    int          mcnt;
    logic [31:0] h_data;
    logic        h_err;
    logic [4:0]  h_rd;
    exp_t        f;
    seen = 1'b0; mcnt = 0; h_data = '0; h_err = 1'b0; h_rd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        mcnt = 0;
      end else begin
        chk("req_ready", 32'(bus.req_ready), 32'(q.size() == 0));
        if (q.size() == 0) begin
          chk("mem_en_idle", 32'(mem_en), 32'd0);
          chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        end else begin
          f = q[0];
          if (mem_en) begin
            mcnt++;
            chk("mem_addr", mem_addr, f.addr);
            chk("mem_wr", 32'(mem_wr), 32'(f.wr));
            chk("mem_wscope", 32'(mem_wscope), 32'(f.size));
            chk("mem_wdata", mem_wdata, f.wdata);
          end
          if (bus.rsp_valid) begin
            if (!seen) begin
              last_data = bus.rsp_data;
              last_err  = bus.rsp_err;
              last_lat  = cyc - f.acc + 1;
              chk("rsp_data", bus.rsp_data, f.data);
              chk("rsp_err", 32'(bus.rsp_err), 32'(f.err));
              chk("rsp_rd", 32'(bus.rsp_rd), 32'(f.rd));
              chk("latency", 32'(last_lat), 32'(f.lat));
              chk("mem_en_count", 32'(mcnt), f.err ? 32'd0 : 32'd1);
              h_data = bus.rsp_data; h_err = bus.rsp_err; h_rd = bus.rsp_rd;
              seen = 1'b1;
            end else begin
              chk("hold_data", bus.rsp_data, h_data);
              chk("hold_err", 32'(bus.rsp_err), 32'(h_err));
              chk("hold_rd", 32'(bus.rsp_rd), 32'(h_rd));
              chk("hold_mem_en", 32'(mem_en), 32'd0);
            end
            if (bus.rsp_ready) begin
              void'(q.pop_front());
              seen = 1'b0;
              mcnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    exp_t e;
    int n;
    e = model(wr, size, sgn, addr, wdata, rd);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    e.acc = cyc;
    q.push_back(e);
    bus.req_valid = 1'b0;
  endtask

  task automatic await_rsp(input logic [31:0] xd, input logic xe, input int xl);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_timeout", 32'(q.size()), 32'd0);
    if (q.size() != 0) q.delete();
    chk("lit_data", last_data, xd);
    chk("lit_err", 32'(last_err), 32'(xe));
    chk("lit_lat", 32'(last_lat), 32'(xl));
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] xd, input logic xe, input int xl);
    send(wr, size, sgn, addr, wdata, rd);
    await_rsp(xd, xe, xl);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    chk({tag, "_rsp_rd"}, 32'(bus.rsp_rd), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wscope"}, 32'(mem_wscope), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  localparam logic [1:0] W = 2'b11, H = 2'b01, B = 2'b00, RSV = 2'b10;

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0; bus.rsp_ready = 1'b1;
    last_data = '0; last_err = 1'b0; last_lat = 0;
    #2 rst_n = 1'b0;
    #2 chk_reset_outputs("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, W, 0, 32'h10, 32'hDEAD_BEEF, 5'd1, 32'h0, 0, 2);
    issue(0, W, 0, 32'h10, 32'h0, 5'd2, 32'hDEAD_BEEF, 0, 3);
    issue(0, B, 1, 32'h11, 32'h0, 5'd3, 32'hFFFF_FFAD, 0, 3);
    issue(0, B, 0, 32'h11, 32'h0, 5'd4, 32'h0000_00AD, 0, 3);
    issue(0, H, 1, 32'h12, 32'h0, 5'd5, 32'hFFFF_BEEF, 0, 3);
    issue(1, B, 0, 32'h13, 32'hAAAA_AA7F, 5'd6, 32'h0, 0, 2);
    issue(0, W, 0, 32'h10, 32'h0, 5'd7, 32'hDEAD_BE7F, 0, 3);
    issue(1, H, 0, 32'h10, 32'hFFFF_1234, 5'd8, 32'h0, 0, 2);
    issue(0, W, 0, 32'h10, 32'h0, 5'd9, 32'h1234_BE7F, 0, 3);
    issue(0, RSV, 0, 32'h10, 32'h0, 5'd10, 32'h0, 1, 1);
    issue(1, RSV, 0, 32'h10, 32'h5555_5555, 5'd11, 32'h0, 1, 1);
    issue(0, W, 0, 32'h1F9C, 32'h0, 5'd12, 32'h0, 0, 3);
    issue(0, W, 0, 32'h1FA0, 32'h0, 5'd13, 32'h0, 1, 1);
    issue(0, B, 0, 32'h1F9F, 32'h0, 5'd14, 32'h0, 0, 3);
    issue(0, H, 0, 32'h1F9F, 32'h0, 5'd15, 32'h0, 1, 1);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    issue(0, W, 0, 32'h12, 32'h0, 5'd16, 32'h0, 1, 1);
    issue(0, H, 1, 32'h11, 32'h0, 5'd17, 32'h0, 1, 1);
`else
    issue(0, W, 0, 32'h12, 32'h0, 5'd16, 32'h1234_BE7F, 0, 3);
    issue(0, H, 1, 32'h11, 32'h0, 5'd17, 32'h0000_1234, 0, 3);
`endif
    issue(1, W, 0, 32'h20, 32'h8000_0001, 5'd18, 32'h0, 0, 2);
    issue(0, H, 1, 32'h22, 32'h0, 5'd19, 32'h0000_0001, 0, 3);
    issue(0, H, 1, 32'h20, 32'h0, 5'd20, 32'hFFFF_8000, 0, 3);
    issue(0, B, 0, 32'h20, 32'h0, 5'd21, 32'h0000_0080, 0, 3);
    issue(0, B, 1, 32'h23, 32'h0, 5'd22, 32'h0000_0001, 0, 3);

    // Stalled response must stay stable with no memory activity.
    bus.rsp_ready = 1'b0;
    send(0, W, 0, 32'h10, 32'h0, 5'd23);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("stall_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    await_rsp(32'h1234_BE7F, 0, 3);

    // Reset during ACCESS drops the request without a response.
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_size = W; bus.req_signed = 1'b0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h0; bus.req_rd = 5'd24;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("pre_reset_mem_en", 32'(mem_en), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midop_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("dropped_no_rsp", 32'(bus.rsp_valid), 32'd0);

    issue(0, B, 1, 32'h12, 32'h0, 5'd25, 32'hFFFF_FFBE, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
